clk_div_prog: RTL and testbench

Multi-channel, runtime-programmable clock divider; the parametrised successor of the fixed `clk_div`. Each channel derives a registered square-wave `clk_out` and a one-cycle `tick` enable from the single system clock `clk`, with its divisor reloadable over a valid/ready config port. Sits beside the board clock tree: it feeds blinkers, UART baud generators and display scanners, which need several independent rates without extra PLLs.

---
 rtl/clk_div_prog_pkg.sv | 29 ++
 rtl/clk_div_prog_chan.sv | 113 +++++++++++
 rtl/clk_div_prog.sv | 60 ++++++
 tb/tb_clk_div_prog.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_prog_pkg.sv
// Shared definitions for the programmable multi-channel clock divider:
// the "off" divisor value, the per-edge channel action encoding and the
// channel-index width helper.
package clk_div_prog_pkg;

    // Divisor value that parks a channel (no tick, clk_out low).
    localparam int DIV_OFF = 0;

    // What a channel does on a given edge, in priority order.
    typedef enum logic [2:0] {
        ACT_STOP  = 3'd0,   // run enable low
        ACT_SYNC  = 3'd1,   // phase-align pulse
        ACT_OFF   = 3'd2,   // divisor is DIV_OFF
        ACT_WRAP  = 3'd3,   // last cycle of the period
        ACT_COUNT = 3'd4    // ordinary count step
    } chan_act_e;

    // Width of the channel-select field; never narrower than one bit.
    function automatic int chan_idx_w(input int channels);
        int w;
        if (channels > 1) begin
            w = $clog2(channels);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_prog_chan.sv
// One divider channel: period counter, active and pending divisor, and
// registered clk_out / tick. A pending divisor only takes over at a period
// boundary (wrap, sync, stop or off), so the running period always completes.
module clk_div_prog_chan
    import clk_div_prog_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] ZERO    = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH-1:0] OFF     = WIDTH'(DIV_OFF);
    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] pend_div_r;
    logic             pend_v_r;
    logic             out_r;
    logic             tick_r;

    chan_act_e        act_s;
    logic [WIDTH-1:0] n_eff_s;
    logic [WIDTH-1:0] cnt_inc_s;

    // Pick this edge's action by priority and the divisor in force after a boundary
    always_comb begin
        cnt_inc_s = cnt_r + ONE;
        if (!en) begin
            act_s = ACT_STOP;
        end else if (sync) begin
            act_s = ACT_SYNC;
        end else if (div_r == OFF) begin
            act_s = ACT_OFF;
        end else if (cnt_r == (div_r - ONE)) begin
            act_s = ACT_WRAP;
        end else begin
            act_s = ACT_COUNT;
        end
        if (pend_v_r) begin
            n_eff_s = pend_div_r;
        end else begin
            n_eff_s = div_r;
        end
    end

    // Counter, divisor hand-over, config capture and output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= ZERO;
            div_r      <= RST_DIV;
            pend_div_r <= RST_DIV;
            pend_v_r   <= 1'b0;
            out_r      <= 1'b0;
            tick_r     <= 1'b0;
        end else begin
            case (act_s)
                ACT_STOP: begin
                    cnt_r  <= ZERO;
                    out_r  <= 1'b0;
                    tick_r <= 1'b0;
                end
                ACT_SYNC, ACT_OFF: begin
                    cnt_r  <= ZERO;
                    out_r  <= (n_eff_s >= TWO);
                    tick_r <= 1'b0;
                end
                ACT_WRAP: begin
                    cnt_r  <= ZERO;
                    out_r  <= (n_eff_s >= TWO);
                    tick_r <= 1'b1;
                end
                ACT_COUNT: begin
                    cnt_r  <= cnt_inc_s;
                    out_r  <= (cnt_inc_s < (div_r >> 1));
                    tick_r <= 1'b0;
                end
                default: begin
                    cnt_r  <= ZERO;
                    out_r  <= 1'b0;
                    tick_r <= 1'b0;
                end
            endcase
            // Every action except a plain count step is a period boundary.
            // A new request is only taken while nothing is pending, so it can
            // never be consumed at the edge that accepts it.
            if (pend_v_r && (act_s != ACT_COUNT)) begin
                div_r    <= pend_div_r;
                pend_v_r <= 1'b0;
            end else if (!pend_v_r && wr) begin
                pend_div_r <= wr_div;
                pend_v_r   <= 1'b1;
            end
        end
    end

    assign pend    = pend_v_r;
    assign clk_out = out_r;
    assign tick    = tick_r;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider. Decodes the config port
// into per-channel write strobes and muxes the selected channel's ready back.
// cfg_ch -> cfg_ready is the only combinational path.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int  CHANNELS    = 4,
    parameter int  WIDTH       = 16,
    parameter int  DEFAULT_DIV = 2,
    localparam int CH_W        = chan_idx_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic [CHANNELS-1:0] pend_s;
    logic [CHANNELS-1:0] wr_s;
    logic                in_range_s;

    // Ready mux: a non-existent channel always accepts (and ignores) requests
    always_comb begin
        in_range_s = ({1'b0, cfg_ch} < CH_LIMIT);
        if (in_range_s) begin
            cfg_ready = !pend_s[cfg_ch];
        end else begin
            cfg_ready = 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        // The channel itself refuses the strobe while it holds a pending divisor.
        assign wr_s[g] = cfg_valid && (cfg_ch == CH_W'(g));

        clk_div_prog_chan #(
            .WIDTH      (WIDTH),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en     (en[g]),
            .sync   (sync),
            .wr     (wr_s[g]),
            .wr_div (cfg_div),
            .pend   (pend_s[g]),
            .clk_out(clk_out[g]),
            .tick   (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: a constant vector table for the
// start-up pattern, hand-written corner sequences, and a randomized run
// compared against a period-position reference model.
module tb_clk_div_prog;

    localparam int CH  = 5;
    localparam int W   = 16;
    localparam int DEF = 2;
    localparam int CW  = 3;
    localparam logic [CH-1:0] ALL = 5'h1F;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic          sync;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_div;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position inside the current period per channel
    int m_div  [CH];
    int m_pos  [CH];
    int m_pdiv [CH];
    bit m_pv   [CH];
    bit m_out  [CH];
    bit m_tick [CH];

    typedef struct {
        logic [CH-1:0] en;
        logic          sync;
        logic          cv;
        logic [CW-1:0] ch;
        logic [W-1:0]  dv;
        logic [CH-1:0] e_out;
        logic [CH-1:0] e_tick;
        logic          e_ready;
    } vec_t;

    vec_t tbl [6];

    clk_div_prog #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= CH) begin
            return 1'b1;
        end
        return !m_pv[cfg_ch];
    endfunction

    // One clock edge of the model, from the inputs presented to that edge
    task automatic model_edge();
        bit acc [CH];
        for (int c = 0; c < CH; c++) begin
            acc[c] = cfg_valid && (int'(cfg_ch) == c) && !m_pv[c];
        end
        for (int c = 0; c < CH; c++) begin
            bit new_period;
            if (rst) begin
                m_pos[c]  = 0;
                m_div[c]  = DEF;
                m_pv[c]   = 1'b0;
                m_out[c]  = 1'b0;
                m_tick[c] = 1'b0;
            end else begin
                new_period = 1'b1;
                m_tick[c]  = 1'b0;
                if (!en[c] || sync || m_div[c] == 0) begin
                    m_pos[c] = 0;
                end else if (m_pos[c] == m_div[c] - 1) begin
                    m_pos[c]  = 0;
                    m_tick[c] = 1'b1;
                end else begin
                    m_pos[c]++;
                    new_period = 1'b0;
                end
                if (new_period && m_pv[c]) begin
                    m_div[c] = m_pdiv[c];
                    m_pv[c]  = 1'b0;
                end
                m_out[c] = en[c] && (m_pos[c] < m_div[c] / 2);
                if (acc[c]) begin
                    m_pv[c]   = 1'b1;
                    m_pdiv[c] = int'(cfg_div);
                end
            end
        end
    endtask

    // Drive current inputs through one edge and compare against the model
    task automatic do_cycle(input bit chk_ready);
        logic [CH-1:0] eo;
        logic [CH-1:0] et;
        #1;
        if (chk_ready) begin
            check("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
        end
        model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            eo[c] = m_out[c];
            et[c] = m_tick[c];
        end
        check("clk_out", 32'(clk_out), 32'(eo));
        check("tick", 32'(tick), 32'(et));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            do_cycle(1'b1);
        end
    endtask

    // Hold a request until the selected channel accepts it, bounded
    task automatic cfg_write(input int ch, input int dv);
        bit acc;
        acc       = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_div   = W'(dv);
        for (int i = 0; i < 60; i++) begin
            acc = model_ready();
            do_cycle(1'b1);
            if (acc) begin
                break;
            end
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL cfg_write_timeout: ch%0d never accepted, expected acceptance", ch);
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_t;
        int cnt_h;
        int co [$];

        rst = 1'b1; en = '0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;

        // start-up vectors from cycle 0, default N=2 on every channel
        tbl[0] = '{ALL, 1'b0, 1'b0, 3'd0, 16'd0, 5'h00, 5'h00, 1'b1};
        tbl[1] = '{ALL, 1'b0, 1'b0, 3'd0, 16'd0, ALL,   ALL,   1'b1};
        tbl[2] = '{ALL, 1'b0, 1'b0, 3'd0, 16'd0, 5'h00, 5'h00, 1'b1};
        tbl[3] = '{ALL, 1'b0, 1'b1, 3'd6, 16'd9, ALL,   ALL,   1'b1};
        tbl[4] = '{ALL, 1'b0, 1'b1, 3'd7, 16'd3, 5'h00, 5'h00, 1'b1};
        tbl[5] = '{ALL, 1'b0, 1'b0, 3'd0, 16'd0, ALL,   ALL,   1'b1};

        do_cycle(1'b0);
        rst = 1'b0;
        en  = ALL;
        #1;
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_ready", 32'(cfg_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            en = tbl[i].en; sync = tbl[i].sync;
            cfg_valid = tbl[i].cv; cfg_ch = tbl[i].ch; cfg_div = tbl[i].dv;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].e_ready));
            model_edge();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_clk_out", i), 32'(clk_out), 32'(tbl[i].e_out));
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].e_tick));
        end
        cfg_valid = 1'b0;

        // ch1 -> N=5 mid-period: ready low until the switch, then 2 high / 3 low
        cfg_write(1, 5);
        #1;
        check("ch1_ready_pending", 32'(cfg_ready), 32'd0);
        run(2);
        #1;
        check("ch1_ready_after_switch", 32'(cfg_ready), 32'd1);
        cnt_t = 0; cnt_h = 0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1);
            cnt_t += int'(tick[1]);
            cnt_h += int'(clk_out[1]);
        end
        check("ch1_ticks_per_20", 32'(cnt_t), 32'd4);
        check("ch1_highs_per_20", 32'(cnt_h), 32'd8);

        // back-to-back writes to ch0 stall; ch2 is accepted in the same window
        cfg_write(0, 3);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd7;
        #1;
        check("ch0_second_write_stalled", 32'(cfg_ready), 32'd0);
        cfg_ch = 3'd2; cfg_div = 16'd1;
        #1;
        check("ch2_write_free", 32'(cfg_ready), 32'd1);
        do_cycle(1'b1);
        cfg_write(0, 7);

        // ch2 N=1: tick every cycle, clk_out low; then N=0 parks it
        run(3);
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b1);
            check("ch2_n1_tick", 32'(tick[2]), 32'd1);
            check("ch2_n1_clk_out", 32'(clk_out[2]), 32'd0);
        end
        cfg_write(2, 0);
        run(3);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1);
            check("ch2_off_tick", 32'(tick[2]), 32'd0);
            check("ch2_off_clk_out", 32'(clk_out[2]), 32'd0);
        end

        // ch0 N=4 and ch3 N=6 phase-aligned by sync: ticks coincide every 12
        cfg_write(0, 4);
        cfg_write(3, 6);
        run(16);
        sync = 1'b1;
        do_cycle(1'b1);
        sync = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            do_cycle(1'b1);
            if (tick[0] && tick[3]) begin
                co.push_back(i);
            end
        end
        check("sync_coincidences", 32'(co.size()), 32'd2);
        if (co.size() >= 2) begin
            check("sync_first_coincidence", 32'(co[0]), 32'd12);
            check("sync_coincidence_gap", 32'(co[1] - co[0]), 32'd12);
        end

        // reset while an update is pending discards it and restores N=2
        cfg_write(1, 9);
        rst = 1'b1;
        do_cycle(1'b1);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        cfg_ch = 3'd1;
        #1;
        check("rst_pending_dropped", 32'(cfg_ready), 32'd1);
        cnt_t = 0;
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1);
            cnt_t += int'(tick[1]);
        end
        check("rst_default_div_ticks", 32'(cnt_t), 32'd4);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(99) == 0);
            en        = ($urandom_range(9) == 0) ? CH'($urandom_range(31)) : ALL;
            sync      = ($urandom_range(29) == 0);
            cfg_valid = ($urandom_range(3) == 0);
            cfg_ch    = CW'($urandom_range(7));
            cfg_div   = W'($urandom_range(7));
            do_cycle(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
